fpadd_align_ctrl: RTL and testbench

// - Alignment-setup stage of the FP add/sub datapath. It sits directly upstream of the

---
 rtl/fpadd_pkg.sv | 39 +++
 rtl/fpadd_mag_cmp.sv | 32 +++
 rtl/fpadd_align_ctrl.sv | 156 +++++++++++++++
 tb/tb_fpadd_align_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared constants, types and operand unpacking for the FP add/sub alignment front end.
package fpadd_pkg;

  localparam int unsigned EW   = 8;
  localparam int unsigned FW   = 23;
  localparam int unsigned MW   = FW + 4;
  localparam int unsigned SH_W = $clog2(MW + 1) + 1;
  localparam int unsigned OPW  = 1 + EW + FW;

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_NAN  = 2'b01,
    SP_INF  = 2'b10
  } special_e;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          is_nan;
    logic          is_inf;
  } operand_t;

  // Denormals are flushed: a zero exponent yields a zero mantissa with no hidden bit.
  function automatic operand_t unpack(input logic [OPW-1:0] x);
    operand_t      o;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    e        = x[EW+FW-1:FW];
    f        = x[FW-1:0];
    o.sign   = x[EW+FW];
    o.exp    = e;
    o.mant   = (e != '0) ? {1'b1, f, 3'b000} : '0;
    o.is_nan = (&e) & (|f);
    o.is_inf = (&e) & ~(|f);
    return o;
  endfunction

endpackage

// File: rtl/fpadd_mag_cmp.sv
// Magnitude compare of two unpacked operands; routes the larger to L and the smaller to S.
module fpadd_mag_cmp
  import fpadd_pkg::*;
(
  input  logic          sign_a_i,
  input  logic [EW-1:0] exp_a_i,
  input  logic [MW-1:0] mant_a_i,
  input  logic          sign_b_i,
  input  logic [EW-1:0] exp_b_i,
  input  logic [MW-1:0] mant_b_i,
  output logic          sign_l_o,
  output logic [EW-1:0] exp_l_o,
  output logic [MW-1:0] mant_l_o,
  output logic [MW-1:0] mant_s_o,
  output logic [EW-1:0] exp_diff_o
);

  logic          swap;
  logic [EW-1:0] exp_s;

  always_comb begin
    // The mantissa already carries the hidden bit, so {exp, mant} orders by magnitude; ties keep A.
    swap       = {exp_b_i, mant_b_i} > {exp_a_i, mant_a_i};
    sign_l_o   = swap ? sign_b_i : sign_a_i;
    exp_l_o    = swap ? exp_b_i  : exp_a_i;
    exp_s      = swap ? exp_a_i  : exp_b_i;
    mant_l_o   = swap ? mant_b_i : mant_a_i;
    mant_s_o   = swap ? mant_a_i : mant_b_i;
    exp_diff_o = exp_l_o - exp_s;
  end

endmodule

// File: rtl/fpadd_align_ctrl.sv
// Two-stage alignment setup for the FP adder: operand swap, exponent difference and
// saturated right-shift amount for the downstream barrel shifter.
module fpadd_align_ctrl
  import fpadd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  input  logic            in_op_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MW-1:0]   out_mant_small,
  output logic [SH_W-1:0] out_sh,
  output logic            out_sh_tc,
  output logic            out_data_tc,
  output logic            out_sh_mode,
  output logic [MW-1:0]   out_mant_large,
  output logic [EW-1:0]   out_exp_large,
  output logic            out_sign_res,
  output logic            out_eff_sub,
  output logic [1:0]      out_special
);

  localparam logic [EW-1:0] MaxShift = EW'(MW);

  operand_t op_a, op_b;
  logic     eff_sub;
  special_e special_d;

  logic          cmp_sign_l;
  logic [EW-1:0] cmp_exp_l;
  logic [MW-1:0] cmp_mant_l, cmp_mant_s;
  logic [EW-1:0] cmp_diff;

  logic          s1_valid_q;
  logic [MW-1:0] s1_mant_l_q, s1_mant_s_q;
  logic [EW-1:0] s1_exp_l_q, s1_diff_q;
  logic          s1_sign_q, s1_eff_sub_q;
  special_e      s1_special_q;

  logic            s2_valid_q;
  logic [MW-1:0]   s2_mant_l_q, s2_mant_s_q;
  logic [EW-1:0]   s2_exp_l_q;
  logic [SH_W-1:0] s2_sh_q;
  logic            s2_sign_q, s2_eff_sub_q;
  special_e        s2_special_q;

  logic [EW-1:0]   sat;
  logic [SH_W-1:0] sh_d;
  logic            s2_adv, s1_adv, in_xfer;

  always_comb begin
    op_a      = unpack(in_a);
    op_b      = unpack(in_b);
    op_b.sign = op_b.sign ^ in_op_sub;
    eff_sub   = op_a.sign ^ op_b.sign;
  end

  // An Inf always lands on the L side, so the result sign is simply the larger operand's sign.
  always_comb begin
    special_d = SP_NORM;
    if (op_a.is_nan || op_b.is_nan) begin
      special_d = SP_NAN;
    end else if (op_a.is_inf && op_b.is_inf && eff_sub) begin
      special_d = SP_NAN;
    end else if (op_a.is_inf || op_b.is_inf) begin
      special_d = SP_INF;
    end
  end

  fpadd_mag_cmp u_mag_cmp (
    .sign_a_i   (op_a.sign),
    .exp_a_i    (op_a.exp),
    .mant_a_i   (op_a.mant),
    .sign_b_i   (op_b.sign),
    .exp_b_i    (op_b.exp),
    .mant_b_i   (op_b.mant),
    .sign_l_o   (cmp_sign_l),
    .exp_l_o    (cmp_exp_l),
    .mant_l_o   (cmp_mant_l),
    .mant_s_o   (cmp_mant_s),
    .exp_diff_o (cmp_diff)
  );

  always_comb begin
    sat  = (s1_diff_q > MaxShift) ? MaxShift : s1_diff_q;
    sh_d = -(SH_W'(sat));
  end

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_adv;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mant_l_q  <= '0;
      s1_mant_s_q  <= '0;
      s1_exp_l_q   <= '0;
      s1_diff_q    <= '0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_special_q <= SP_NORM;
      s2_valid_q   <= 1'b0;
      s2_mant_l_q  <= '0;
      s2_mant_s_q  <= '0;
      s2_exp_l_q   <= '0;
      s2_sh_q      <= '0;
      s2_sign_q    <= 1'b0;
      s2_eff_sub_q <= 1'b0;
      s2_special_q <= SP_NORM;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_xfer) begin
        s1_mant_l_q  <= cmp_mant_l;
        s1_mant_s_q  <= cmp_mant_s;
        s1_exp_l_q   <= cmp_exp_l;
        s1_diff_q    <= cmp_diff;
        s1_sign_q    <= cmp_sign_l;
        s1_eff_sub_q <= eff_sub;
        s1_special_q <= special_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_adv) begin
        s2_mant_l_q  <= s1_mant_l_q;
        s2_mant_s_q  <= s1_mant_s_q;
        s2_exp_l_q   <= s1_exp_l_q;
        s2_sh_q      <= sh_d;
        s2_sign_q    <= s1_sign_q;
        s2_eff_sub_q <= s1_eff_sub_q;
        s2_special_q <= s1_special_q;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_mant_small = s2_mant_s_q;
  assign out_mant_large = s2_mant_l_q;
  assign out_exp_large  = s2_exp_l_q;
  assign out_sh         = s2_sh_q;
  assign out_sign_res   = s2_sign_q;
  assign out_eff_sub    = s2_eff_sub_q;
  assign out_special    = s2_special_q;
  assign out_sh_tc      = 1'b1;
  assign out_data_tc    = 1'b0;
  assign out_sh_mode    = 1'b1;

endmodule

// File: tb/tb_fpadd_align_ctrl.sv
// Self-checking bench for fpadd_align_ctrl: directed vectors, back-pressure, reset flush and
// randomized traffic against an arithmetic reference model.
module tb_fpadd_align_ctrl;

  typedef struct packed {
    logic [26:0] ms;
    logic [5:0]  sh;
    logic [26:0] ml;
    logic [7:0]  el;
    logic        sr;
    logic        es;
    logic [1:0]  sp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_op_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [26:0] out_mant_small, out_mant_large;
  logic [5:0]  out_sh;
  logic [7:0]  out_exp_large;
  logic        out_sh_tc, out_data_tc, out_sh_mode, out_sign_res, out_eff_sub;
  logic [1:0]  out_special;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fpadd_align_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_op_sub      (in_op_sub),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mant_small (out_mant_small),
    .out_sh         (out_sh),
    .out_sh_tc      (out_sh_tc),
    .out_data_tc    (out_data_tc),
    .out_sh_mode    (out_sh_mode),
    .out_mant_large (out_mant_large),
    .out_exp_large  (out_exp_large),
    .out_sign_res   (out_sign_res),
    .out_eff_sub    (out_eff_sub),
    .out_special    (out_special)
  );

  function automatic res_t observed();
    return {out_mant_small, out_sh, out_mant_large, out_exp_large, out_sign_res, out_eff_sub,
            out_special};
  endfunction

  // Mantissa/shift/exponent are don't-care for specials; NaN sign is unspecified.
  function automatic res_t mask(input res_t r);
    res_t m = r;
    if (m.sp != 2'b00) begin
      m.ms = '0;
      m.sh = '0;
      m.ml = '0;
      m.el = '0;
      if (m.sp == 2'b01) m.sr = 1'b0;
    end
    return m;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t        r;
    int unsigned ea, eb, el, es, diff, sat;
    logic [26:0] ma, mb;
    logic        sa, sb, a_big, nan_a, nan_b;
    ea    = a[30:23];
    eb    = b[30:23];
    ma    = (ea != 0) ? {1'b1, a[22:0], 3'b000} : 27'd0;
    mb    = (eb != 0) ? {1'b1, b[22:0], 3'b000} : 27'd0;
    sa    = a[31];
    sb    = b[31] ^ sub;
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    diff  = el - es;
    sat   = (diff > 27) ? 27 : diff;
    r.ms  = a_big ? mb : ma;
    r.ml  = a_big ? ma : mb;
    r.el  = 8'(el);
    r.sh  = 6'(64 - sat);
    r.sr  = a_big ? sa : sb;
    r.es  = sa ^ sb;
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    if (nan_a || nan_b) r.sp = 2'b01;
    else if (ea == 255 && eb == 255 && r.es) r.sp = 2'b01;
    else if (ea == 255) begin r.sp = 2'b10; r.sr = sa; end
    else if (eb == 255) begin r.sp = 2'b10; r.sr = sb; end
    else r.sp = 2'b00;
    return r;
  endfunction

  function automatic logic [31:0] rand_op(input logic [7:0] near, input bit use_near);
    int          r, ne;
    logic [7:0]  e;
    logic [22:0] f;
    r = int'($urandom_range(0, 11));
    f = 23'($urandom);
    if (use_near && r >= 4) begin
      ne = int'(near) + int'($urandom_range(0, 70)) - 35;
      if (ne < 1) ne = 1;
      if (ne > 254) ne = 254;
      e = 8'(ne);
    end else if (r == 0) e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else e = 8'($urandom_range(1, 254));
    if (e == 8'hFF && $urandom_range(0, 1) == 0) f = '0;
    if (e == 8'h00) f = '0;
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op_sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", observed());
    end
    n_checks++;
    if ({out_sh_tc, out_data_tc, out_sh_mode} !== 3'b101) begin
      n_fail++;
      $display("FAIL tieoffs: got %b want 101", {out_sh_tc, out_data_tc, out_sh_mode});
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[8], vb[8];
    logic        vs[8];
    res_t        vr[8];
    string       vn[8];
    res_t        got;
    vn[0] = "one_plus_one";  va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vs[0] = 1'b0;
    vr[0] = {27'h4000000, 6'h00, 27'h4000000, 8'h7F, 1'b0, 1'b0, 2'b00};
    vn[1] = "quarter_swap";  va[1] = 32'h3E800000; vb[1] = 32'h3F800000; vs[1] = 1'b0;
    vr[1] = {27'h4000000, 6'h3E, 27'h4000000, 8'h7F, 1'b0, 1'b0, 2'b00};
    vn[2] = "sat_shift";     va[2] = 32'h3F800000; vb[2] = 32'h2B800000; vs[2] = 1'b0;
    vr[2] = {27'h4000000, 6'h25, 27'h4000000, 8'h7F, 1'b0, 1'b0, 2'b00};
    vn[3] = "one_minus_one"; va[3] = 32'h3F800000; vb[3] = 32'h3F800000; vs[3] = 1'b1;
    vr[3] = {27'h4000000, 6'h00, 27'h4000000, 8'h7F, 1'b0, 1'b1, 2'b00};
    vn[4] = "inf_minus_inf"; va[4] = 32'h7F800000; vb[4] = 32'h7F800000; vs[4] = 1'b1;
    vr[4] = {27'h0, 6'h00, 27'h0, 8'h00, 1'b0, 1'b1, 2'b01};
    vn[5] = "nan_plus_one";  va[5] = 32'h7FC00000; vb[5] = 32'h3F800000; vs[5] = 1'b0;
    vr[5] = {27'h0, 6'h00, 27'h0, 8'h00, 1'b0, 1'b0, 2'b01};
    vn[6] = "inf_plus_one";  va[6] = 32'h7F800000; vb[6] = 32'h3F800000; vs[6] = 1'b0;
    vr[6] = {27'h0, 6'h00, 27'h0, 8'h00, 1'b0, 1'b0, 2'b10};
    vn[7] = "one_minus_inf"; va[7] = 32'h3F800000; vb[7] = 32'h7F800000; vs[7] = 1'b1;
    vr[7] = {27'h0, 6'h00, 27'h0, 8'h00, 1'b1, 1'b1, 2'b10};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_a = va[i]; in_b = vb[i]; in_op_sub = vs[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_ready: in_ready=%b want 1", vn[i], in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early: out_valid=%b want 0 after 1 cycle", vn[i], out_valid);
      end
      @(negedge clk);
      #1;
      got = observed();
      n_checks++;
      if (out_valid !== 1'b1 || mask(got) !== mask(vr[i])) begin
        n_fail++;
        $display("FAIL %s: valid=%b got %h want %h", vn[i], out_valid, mask(got), mask(vr[i]));
      end
      n_checks++;
      if (mask(got) !== mask(model(va[i], vb[i], vs[i]))) begin
        n_fail++;
        $display("FAIL %s_model: got %h want %h", vn[i], mask(got),
                 mask(model(va[i], vb[i], vs[i])));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t        q[$];
    res_t        held, exp_r;
    logic [31:0] pa[4], pb[4];
    logic        ps[4];
    int          sent = 0, got = 0, cyc = 0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op(8'h80, 1'b0);
      pb[i] = rand_op(pa[i][30:23], 1'b1);
      ps[i] = 1'($urandom_range(0, 1));
    end
    held = '0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_a = pa[sent]; in_b = pb[sent]; in_op_sub = ps[sent];
      end
      #1;
      if (cyc == 2) begin
        held = observed();
        n_checks++;
        if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_drop: in_ready=%b accepted=%0d out_valid=%b want 0/2/1",
                   in_ready, sent, out_valid);
        end
      end
      if (cyc == 3 || cyc == 4) begin
        n_checks++;
        if (observed() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall_hold: got %h v=%b r=%b want %h v=1 r=0", observed(),
                   out_valid, in_ready, held);
        end
      end
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got %h want nothing", observed());
        end else begin
          exp_r = q.pop_front();
          if (mask(observed()) !== mask(exp_r)) begin
            n_fail++;
            $display("FAIL b2b_order: got %h want %h", mask(observed()), mask(exp_r));
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_op_sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d results want 4", got);
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 32'h40000000; in_b = 32'h3F800000; in_op_sub = 1'b0;
    @(negedge clk);
    in_a = 32'h40400000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: out_valid=%b want 1", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_flush: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: %0d cycles with out_valid want 0", stale);
    end
  endtask

  task automatic test_random();
    res_t        q[$];
    res_t        exp_r;
    logic [31:0] a, b;
    logic        s;
    bit          have = 1'b0;
    int          sent = 0, recv = 0, cyc = 0;
    localparam int N = 400;
    a = '0; b = '0; s = 1'b0;
    while (recv < N && cyc < 20000) begin
      @(negedge clk);
      if (!have && sent < N) begin
        a = rand_op(8'h00, 1'b0);
        if ($urandom_range(0, 9) == 0) b = {a[31] ^ 1'($urandom_range(0, 1)), a[30:0]};
        else b = rand_op(a[30:23], 1'b1);
        s = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(0, 3) != 0);
      in_a = a; in_b = b; in_op_sub = s;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      n_checks++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_fail++;
        $display("FAIL rnd_in_ready: got %b want %b (in flight %0d)", in_ready,
                 (q.size() < 2) || out_ready, q.size());
      end
      if (out_valid && out_ready) begin
        recv++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra: got %h want nothing", observed());
        end else begin
          exp_r = q.pop_front();
          if (mask(observed()) !== mask(exp_r)) begin
            n_fail++;
            $display("FAIL rnd_data: got %h want %h", mask(observed()), mask(exp_r));
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, s));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != N) begin
      n_fail++;
      $display("FAIL rnd_timeout: received %0d want %0d", recv, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
